sseg_scan_driver: RTL and testbench

//  Parametrised multiplexed seven-segment scanner. Successor to the fixed 8-digit driver.

---
 rtl/sseg_pkg.sv | 40 ++++
 rtl/sseg_scan_driver_if.sv | 39 +++
 rtl/sseg_hex_decode.sv | 13 +
 rtl/sseg_scan_driver.sv | 113 +++++++++++
 tb/tb_sseg_scan_driver.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   - digit field offsets inside one 6-bit digit slot {dp, en, hex[3:0]}
//   - blank segment pattern, BLANK/DRIVE state encoding
//   - 16-entry active-low hex glyph table, bit order {g,f,e,d,c,b,a}
package sseg_pkg;

  localparam int unsigned DIG_HEX_LSB = 0;
  localparam int unsigned DIG_EN      = 4;
  localparam int unsigned DIG_DP      = 5;
  localparam int unsigned DIG_W       = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic       dp;
    logic       en;
    logic [3:0] hex;
  } digit_t;

  // Glyphs 0-9, A, b, C, d, E, F (active-low segments).
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Split one raw digit slot into its fields.
  function automatic digit_t unpack_digit(input logic [DIG_W-1:0] raw);
    digit_t d;
    d.dp  = raw[DIG_DP];
    d.en  = raw[DIG_EN];
    d.hex = raw[DIG_HEX_LSB +: 4];
    return d;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Display bundle between digit producers and the scanner.
//   digits      NUM_DIGITS*6  digit i at [6i+5:6i] = {dp, en, hex}
//   brightness  4             dim level (only with SSEG_PWM_DIM_EN)
//   sseg        7             active-low segments {g,f,e,d,c,b,a}
//   dp          1             active-low decimal point
//   AN          NUM_DIGITS    active-low anodes
//   frame_tick  1             pulse on the shadow-load cycle
// master = scanner side, slave = producer/pin side.
// Optional feature macro: SSEG_PWM_DIM_EN.
interface sseg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [NUM_DIGITS*6-1:0] digits;
`ifdef SSEG_PWM_DIM_EN
  logic [3:0]              brightness;
`endif
  logic [6:0]              sseg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    frame_tick;

  modport master (
`ifdef SSEG_PWM_DIM_EN
    input  brightness,
`endif
    input  digits,
    output sseg, dp, AN, frame_tick
  );

  modport slave (
`ifdef SSEG_PWM_DIM_EN
    output brightness,
`endif
    output digits,
    input  sseg, dp, AN, frame_tick
  );

endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
//   hex      in   4  nibble to display
//   glyph_c  out  7  {g,f,e,d,c,b,a}, active-low
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] glyph_c
);

  assign glyph_c = HEX_GLYPH[hex];

endmodule

// File: rtl/sseg_scan_driver.sv
// Parametrised multiplexed seven-segment scanner.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      master modport of sseg_scan_driver_if (digits/brightness in,
//            sseg/dp/AN/frame_tick out, all outputs registered)
// Each digit owns REFRESH_DIV cycles; the first BLANK_CYCLES of a slot keep
// every anode off. Digit values are snapshotted once per frame.
// Optional feature macro: SSEG_PWM_DIM_EN (brightness PWM on the anode).
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  sseg_scan_driver_if.master  bus
);

  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
  localparam int unsigned SLOT_W   = $clog2(REFRESH_DIV);
  localparam int unsigned DIGITS_W = NUM_DIGITS * DIG_W;

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [DIGITS_W-1:0]   shadow;
  state_t                state;

  logic [6:0]            sseg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_tick_q;

  logic [DIG_W-1:0]      raw_c;
  digit_t                cur_c;
  logic [6:0]            glyph_c;
  logic                  slot_end_c;
  logic                  frame_end_c;
  logic                  an_on_c;
  logic [SLOT_W-1:0]     slot_nxt_c;

  // Digit currently selected from the frame snapshot.
  assign raw_c = shadow[idx*DIG_W +: DIG_W];
  assign cur_c = unpack_digit(raw_c);

  assign slot_end_c  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign frame_end_c = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
  assign slot_nxt_c  = slot_end_c ? '0 : slot_cnt + 1'b1;

  sseg_hex_decode u_hex_decode (
    .hex     (cur_c.hex),
    .glyph_c (glyph_c)
  );

`ifdef SSEG_PWM_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running dimming phase; anode enabled for brightness+1 of 16 phases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign an_on_c = cur_c.en && (pwm_cnt <= bus.brightness);
`else
  assign an_on_c = cur_c.en;
`endif

  // Prescaler, digit index, frame snapshot, BLANK/DRIVE state and outputs.
  // State tracks slot_cnt; outputs are formed from the current state so they
  // trail it by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt     <= '0;
      idx          <= '0;
      shadow       <= '0;
      state        <= BLANK;
      sseg_q       <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt <= slot_nxt_c;
      state    <= (slot_nxt_c < SLOT_W'(BLANK_CYCLES)) ? BLANK : DRIVE;

      if (slot_end_c) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end

      if (frame_end_c) begin
        shadow <= bus.digits;
      end
      frame_tick_q <= frame_end_c;

      if (state == DRIVE) begin
        sseg_q <= glyph_c;
        dp_q   <= ~cur_c.dp;
        an_q   <= an_on_c ? ~(NUM_DIGITS'(1) << idx) : '1;
      end else begin
        sseg_q <= SEG_BLANK;
        dp_q   <= 1'b1;
        an_q   <= '1;
      end
    end
  end

  assign bus.sseg       = sseg_q;
  assign bus.dp         = dp_q;
  assign bus.AN         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2). A reference model derives each cycle's expected pins from
// the cycle number since reset and per-frame digit snapshots; a monitor pops
// and compares on the falling edge. Honours SSEG_PWM_DIM_EN when defined.
module tb_sseg_scan_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned RD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = N * RD;
  localparam int unsigned DW    = N * 6;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   sseg;
    logic         dp;
    logic         ft;
    logic         chk_seg;
    int           c;
  } exp_t;

  logic          clk      = 1'b0;
  logic          clk_run  = 1'b1;
  logic          reset_n  = 1'b0;
  logic [DW-1:0] digits_drv = '0;
`ifdef SSEG_PWM_DIM_EN
  logic [3:0]    bright_drv = 4'hF;
`endif

  int vectors     = 0;
  int miscompares = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] snaps[$];
  int            k = 0;

  sseg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  assign bus.digits = digits_drv;
`ifdef SSEG_PWM_DIM_EN
  assign bus.brightness = bright_drv;
`endif

  sseg_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = clk_run ? ~clk : 1'b0;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Reference model: edge k shows the display state of cycle k-1.
  always @(posedge clk or negedge reset_n) begin
    exp_t       e;
    int         c, s, i, f;
    logic [5:0] d;
    logic       lit;
    if (!reset_n) begin
      k = 0;
      snaps.delete();
      snaps.push_back('0);
      exp_q.delete();
    end else begin
      k++;
      if (k % FRAME == 0) snaps.push_back(digits_drv);
      c = k - 1;
      s = c % RD;
      i = (c / RD) % N;
      f = c / FRAME;
      d = 6'(snaps[f] >> (6 * i));
      e.c       = c;
      e.ft      = (k % FRAME == 0);
      e.chk_seg = 1'b1;
      e.an      = '1;
      e.sseg    = 7'h7F;
      e.dp      = 1'b1;
      if (s >= BC) begin
        lit = d[4];
`ifdef SSEG_PWM_DIM_EN
        lit = lit && ((c % 16) <= int'(bright_drv));
`endif
        if (d[4]) begin
          e.sseg = glyph(d[3:0]);
          e.dp   = ~d[5];
        end else begin
          e.chk_seg = 1'b0;
        end
        if (lit) e.an = ~(N'(1) << i);
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every cycle the model has predicted.
  always @(negedge clk) begin
    exp_t e;
    logic bad;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      bad = (bus.AN !== e.an) || (bus.frame_tick !== e.ft) ||
            (e.chk_seg && ((bus.sseg !== e.sseg) || (bus.dp !== e.dp)));
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle%0d: got AN=%h sseg=%h dp=%b ft=%b, want AN=%h sseg=%h dp=%b ft=%b",
                 e.c, bus.AN, bus.sseg, bus.dp, bus.frame_tick,
                 e.an, e.chk_seg ? e.sseg : bus.sseg, e.chk_seg ? e.dp : bus.dp, e.ft);
      end
    end
  end

  task automatic check_blank(input string tag);
    vectors++;
    if (bus.AN !== 4'hF || bus.sseg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got AN=%h sseg=%h dp=%b ft=%b, want AN=f sseg=7f dp=1 ft=0",
               tag, bus.AN, bus.sseg, bus.dp, bus.frame_tick);
    end
  endtask

  task automatic wait_ft(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 2 * FRAME);
    vectors++;
    if (bus.frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: frame_tick not seen in %0d cycles, want a pulse every %0d", tag, n, FRAME);
    end
  endtask

  task automatic random_phase(input int iters);
    for (int r = 0; r < iters; r++) begin
      digits_drv = DW'($urandom);
`ifdef SSEG_PWM_DIM_EN
      bright_drv = (r % 3 == 0) ? 4'd3 : 4'($urandom);
`endif
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_blank("reset_hold");
    reset_n = 1'b1;

    // Dark first frame, then F/3/2/1 glyphs on digits 0..3.
    digits_drv = {6'h11, 6'h12, 6'h13, 6'h1F};
    wait_ft("first_frame");
    wait_ft("pattern_frame");

    // Digit 2 disabled, decimal point on digit 1 only.
    digits_drv = {6'h11, 6'h02, 6'h33, 6'h1F};
    wait_ft("skip_dp_load");
`ifdef SSEG_PWM_DIM_EN
    bright_drv = 4'd3;
`endif
    wait_ft("skip_dp_frame");

    // Mid-frame update must wait for the next frame.
    repeat (3) @(negedge clk);
    digits_drv = DW'($urandom);
    wait_ft("midframe_load");
    wait_ft("midframe_show");

    random_phase(12);

    // Async reset while a digit is lit, with the clock stopped.
    digits_drv = {6'h18, 6'h19, 6'h1A, 6'h1B};
`ifdef SSEG_PWM_DIM_EN
    bright_drv = 4'hF;
`endif
    wait_ft("prereset_load");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.AN === 4'hF && n < FRAME);
    vectors++;
    if (bus.AN === 4'hF) begin
      miscompares++;
      $display("FAIL lit_before_reset: got AN=%h, want one anode low", bus.AN);
    end
    clk_run = 1'b0;
    #13;
    reset_n = 1'b0;
    #1;
    check_blank("async_reset");
    #10;
    reset_n = 1'b1;
    #3;
    clk_run = 1'b1;

    digits_drv = {6'h1C, 6'h3D, 6'h0E, 6'h17};
    wait_ft("post_reset_frame");
    wait_ft("post_reset_show");
    random_phase(6);
    repeat (4) @(negedge clk);

    vectors++;
    if (vectors < 300) begin
      miscompares++;
      $display("FAIL vector_count: got %0d cycles checked, want at least 300", vectors);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
